hyperbus_txn_ctrl: RTL

- Transaction sequencer for the HyperBus interface.
- Accepts one read/write request at a time and drives the PHY per cycle: CS#, three command-address (CA) words, initial latency wait, data burst, then CS# high hold.
- Sits between the front-end request/data streams and the DDR PHY.
- One PHY word is 16 bits per clk_i cycle (one CK period, both edges).

---
 rtl/hyperbus_pkg.sv | 41 ++++
 rtl/hyperbus_lat_cnt.sv | 36 +++
 rtl/hyperbus_txn_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus transaction sequencer: FSM states,
// command-address field layout and default timing values.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA0,
        ST_CA1,
        ST_CA2,
        ST_LAT,
        ST_WDATA,
        ST_RDATA,
        ST_CSHI
    } hyperbus_state_e;

    localparam int CA_RW_BIT    = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_ROW_MSB   = 44;
    localparam int CA_ROW_LSB   = 16;
    localparam int CA_COL_MSB   = 2;
    localparam int CA_COL_LSB   = 0;

    localparam int DEF_LATENCY = 6;
    localparam int DEF_T_CSHI  = 2;

    // Bits CA[15:3] are reserved and always sent as zero; bursts are always linear.
    function automatic logic [47:0] build_ca(input logic       write,
                                             input logic       is_reg,
                                             input logic [31:0] addr);
        logic [47:0] ca;
        ca                            = '0;
        ca[CA_RW_BIT]                 = ~write;
        ca[CA_AS_BIT]                 = is_reg;
        ca[CA_BURST_BIT]              = 1'b1;
        ca[CA_ROW_MSB:CA_ROW_LSB]     = addr[31:3];
        ca[CA_COL_MSB:CA_COL_LSB]     = addr[2:0];
        return ca;
    endfunction

endpackage

// File: rtl/hyperbus_lat_cnt.sv
// Loadable saturating down-counter; done_o flags the final counted cycle so the
// owner can leave its state after exactly load_val_i decrementing cycles.
module hyperbus_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/hyperbus_txn_ctrl.sv
// HyperBus transaction sequencer: CS#, three CA words, initial latency, data burst,
// CS# high hold. Optional read-stall watchdog enabled by HYPERBUS_RD_TIMEOUT_EN.
module hyperbus_txn_ctrl
    import hyperbus_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int BURST_W = 8,
    parameter int T_CSHI  = DEF_T_CSHI
`ifdef HYPERBUS_RD_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic               req_reg_i,
    input  logic [31:0]        req_addr_i,
    input  logic [BURST_W-1:0] req_len_i,
    input  logic               wvalid_i,
    output logic               wready_o,
    input  logic [15:0]        wdata_i,
    input  logic [1:0]         wstrb_i,
    output logic               rvalid_o,
    output logic [15:0]        rdata_o,
    output logic               rlast_o,
    output logic               busy_o,
    output logic               phy_cs_no,
    output logic               phy_clk_en_o,
    output logic               phy_tx_valid_o,
    output logic [15:0]        phy_tx_data_o,
    output logic [1:0]         phy_tx_mask_o,
    input  logic               phy_rwds_i,
    input  logic               phy_rx_valid_i,
    input  logic [15:0]        phy_rx_data_i
`ifdef HYPERBUS_RD_TIMEOUT_EN
    ,
    output logic               err_timeout_o
`endif
);

    localparam int LAT_W  = $clog2(2 * LATENCY + 1);
    localparam int CSHI_W = $clog2(T_CSHI + 1);
    localparam logic [LAT_W-1:0]  LAT_SGL  = LAT_W'(LATENCY - 3);
    localparam logic [LAT_W-1:0]  LAT_DBL  = LAT_W'(2 * LATENCY - 3);
    localparam logic [CSHI_W-1:0] CSHI_VAL = CSHI_W'(T_CSHI);

    hyperbus_state_e    state_q, state_d;
    logic               write_q, write_d;
    logic               reg_q, reg_d;
    logic [31:0]        addr_q, addr_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic               rwds_q, rwds_d;

    logic cs_n_q, cs_n_d;
    logic clk_en_q, clk_en_d;
    logic ca_tx_q, ca_tx_d;
    logic wr_q, wr_d;
    logic rd_q, rd_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;

    logic [47:0]       ca;
    logic [LAT_W-1:0]  lat_val;
    logic              lat_load;
    logic              lat_done;
    logic              cshi_load;
    logic              cshi_done;
    logic              last_beat;
    logic              rlast;
    logic              tmo_hit;

    assign ca        = build_ca(write_q, reg_q, addr_q);
    assign last_beat = (beat_q == (len_q - BURST_W'(1)));
    // An RWDS sample in CA2 must still double the latency that is loaded in that cycle.
    assign lat_val   = (rwds_q || phy_rwds_i) ? LAT_DBL : LAT_SGL;

    hyperbus_lat_cnt #(.W(LAT_W)) u_lat_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (lat_load),
        .load_val_i (lat_val),
        .dec_i      (state_q == ST_LAT),
        .done_o     (lat_done)
    );

    hyperbus_lat_cnt #(.W(CSHI_W)) u_cshi_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cshi_load),
        .load_val_i (CSHI_VAL),
        .dec_i      (state_q == ST_CSHI),
        .done_o     (cshi_done)
    );

`ifdef HYPERBUS_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic tmo_load;
    logic tmo_done;

    // Watchdog restarts on RDATA entry and on every captured word.
    assign tmo_load = ((state_d == ST_RDATA) && (state_q != ST_RDATA)) ||
                      ((state_q == ST_RDATA) && phy_rx_valid_i);

    hyperbus_lat_cnt #(.W(TMO_W)) u_tmo_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmo_load),
        .load_val_i (TMO_W'(TIMEOUT)),
        .dec_i      (state_q == ST_RDATA),
        .done_o     (tmo_done)
    );

    assign err_timeout_o = tmo_hit;
`endif

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        reg_d     = reg_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        rwds_d    = rwds_q;
        lat_load  = 1'b0;
        cshi_load = 1'b0;
        rlast     = 1'b0;
        tmo_hit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    write_d = req_write_i;
                    reg_d   = req_reg_i;
                    addr_d  = req_addr_i;
                    len_d   = (req_len_i == '0) ? BURST_W'(1) : req_len_i;
                    beat_d  = '0;
                    rwds_d  = 1'b0;
                    state_d = ST_CA0;
                end
            end
            ST_CA0: begin
                rwds_d  = rwds_q | phy_rwds_i;
                state_d = ST_CA1;
            end
            ST_CA1: begin
                rwds_d  = rwds_q | phy_rwds_i;
                state_d = ST_CA2;
            end
            ST_CA2: begin
                rwds_d = rwds_q | phy_rwds_i;
                if (reg_q && write_q) begin
                    state_d = ST_WDATA;
                end else if (lat_val == '0) begin
                    state_d = write_q ? ST_WDATA : ST_RDATA;
                end else begin
                    lat_load = 1'b1;
                    state_d  = ST_LAT;
                end
            end
            ST_LAT: begin
                if (lat_done) begin
                    state_d = write_q ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (wvalid_i) begin
                    if (last_beat) begin
                        cshi_load = 1'b1;
                        state_d   = ST_CSHI;
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                    end
                end
            end
            ST_RDATA: begin
                if (phy_rx_valid_i) begin
                    if (last_beat) begin
                        rlast     = 1'b1;
                        cshi_load = 1'b1;
                        state_d   = ST_CSHI;
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                    end
                end
`ifdef HYPERBUS_RD_TIMEOUT_EN
                else if (tmo_done) begin
                    tmo_hit   = 1'b1;
                    rlast     = 1'b1;
                    cshi_load = 1'b1;
                    state_d   = ST_CSHI;
                end
`endif
            end
            ST_CSHI: begin
                if (cshi_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cs_n_d   = (state_d == ST_IDLE) || (state_d == ST_CSHI);
        clk_en_d = (state_d inside {ST_CA0, ST_CA1, ST_CA2, ST_LAT, ST_RDATA});
        ca_tx_d  = (state_d inside {ST_CA0, ST_CA1, ST_CA2});
        wr_d     = (state_d == ST_WDATA);
        rd_d     = (state_d == ST_RDATA);
        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            reg_q    <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            rwds_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            clk_en_q <= 1'b0;
            ca_tx_q  <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            reg_q    <= reg_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            rwds_q   <= rwds_d;
            cs_n_q   <= cs_n_d;
            clk_en_q <= clk_en_d;
            ca_tx_q  <= ca_tx_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Write-phase CK and DQ follow wvalid_i directly so a stall freezes the bus.
    always_comb begin
        phy_tx_data_o = '0;
        case (state_q)
            ST_CA0:   phy_tx_data_o = ca[47:32];
            ST_CA1:   phy_tx_data_o = ca[31:16];
            ST_CA2:   phy_tx_data_o = ca[15:0];
            ST_WDATA: phy_tx_data_o = wdata_i;
            default:  phy_tx_data_o = '0;
        endcase
    end

    assign phy_cs_no      = cs_n_q;
    assign phy_clk_en_o   = clk_en_q | (wr_q & wvalid_i);
    assign phy_tx_valid_o = ca_tx_q | (wr_q & wvalid_i);
    assign phy_tx_mask_o  = wr_q ? ~wstrb_i : 2'b00;
    assign wready_o       = wr_q;
    assign rvalid_o       = rd_q & phy_rx_valid_i;
    assign rdata_o        = rd_q ? phy_rx_data_i : 16'h0000;
    assign rlast_o        = rlast;
    assign req_ready_o    = ready_q;
    assign busy_o         = busy_q;

endmodule
